// File: rtl/axis_pixel_packer_if.sv
// AXI-Stream bundle shared by the pixel input (8-bit) and the packed word output (32-bit).
// The master modport drives payload and valid; the slave modport drives ready.
interface axis_pixel_packer_if #(
    parameter int DATA_W = 8
) ();
    localparam int KEEP_W = (DATA_W >= 8) ? DATA_W / 8 : 1;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axis_pixel_packer.sv
// axis_pixel_packer: packs 8-bit AXI-Stream pixels into LANES-byte words for an S2MM DMA.
// First pixel of a word lands in byte 0. The last pixel of a frame flushes a partial word
// with tlast=1 and a short tkeep; unused bytes are zero. o_frame_done pulses one cycle after
// the frame's final word is handed off.
// Optional feature macro: AXIS_PACKER_LINE_TLAST_EN
//   defined   - words never straddle lines; each line end closes a word with tlast=1.
//   undefined - tlast only at frame end, words may straddle lines.
// Pixel-side tkeep/tlast are not used; the frame position comes from the pixel counter.
module axis_pixel_packer #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int LANES      = 4
) (
    input  logic                axi_clk,
    input  logic                axi_reset_n,
    axis_pixel_packer_if.slave  s_axis,
    axis_pixel_packer_if.master m_axis,
    output logic                o_frame_done
);
    localparam int PIX_TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int PIX_W     = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;
    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WORD_W    = 8 * LANES;

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_TOTAL - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic              run_q;

    logic              m_valid_q;
    logic [WORD_W-1:0] m_data_q;
    logic [LANES-1:0]  m_keep_q;
    logic              m_last_q;
    logic              m_eof_q;
    logic              frame_done_q;

    logic [WORD_W-1:0] word_d;
    logic [LANES-1:0]  keep_d;
    logic              frame_end;
    logic              line_end;
    logic              word_end;
    logic              s_ready;
    logic              pix_accept;
    logic              out_hs;

    assign frame_end = (pix_q == PIX_LAST);

`ifdef AXIS_PACKER_LINE_TLAST_EN
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    logic [COL_W-1:0] col_q, col_d;

    assign line_end = (col_q == COL_LAST);
    assign col_d    = line_end ? '0 : col_q + 1'b1;

    // Column position within the current line; wraps on every line end.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            col_q <= '0;
        end else if (pix_accept) begin
            col_q <= col_d;
        end
    end
`else
    assign line_end = 1'b0;
`endif

    // A word closes on the last lane, at frame end, or (line mode) at line end.
    assign word_end   = (lane_q == LANE_LAST) || frame_end || line_end;
    // Backpressure only matters for the pixel that would reload a still-occupied output.
    assign s_ready    = run_q && (!word_end || !m_valid_q || m_axis.tready);
    assign pix_accept = s_axis.tvalid && s_ready;
    assign out_hs     = m_valid_q && m_axis.tready;

    assign lane_d = word_end ? '0 : lane_q + 1'b1;
    assign pix_d  = frame_end ? '0 : pix_q + 1'b1;

    // Assemble the outgoing word: stored bytes below the current lane, the live pixel at
    // the current lane, zeros above it. The accumulator update writes the same lane.
    always_comb begin
        word_d = '0;
        keep_d = '0;
        acc_d  = acc_q;
        for (int i = 0; i < LANES; i++) begin
            if (LANE_W'(i) < lane_q) begin
                word_d[8*i +: 8] = acc_q[8*i +: 8];
            end
            if (LANE_W'(i) == lane_q) begin
                word_d[8*i +: 8] = s_axis.tdata;
                acc_d[8*i +: 8]  = s_axis.tdata;
            end
            keep_d[i] = (LANE_W'(i) <= lane_q);
        end
    end

    // Lane/pixel counters and byte accumulator advance on every accepted pixel.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            lane_q <= '0;
            pix_q  <= '0;
            acc_q  <= '0;
        end else if (pix_accept) begin
            lane_q <= lane_d;
            pix_q  <= pix_d;
            acc_q  <= acc_d;
        end
    end

    // Holds the input ready low for the first cycle after reset release.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Output register: reload on a completing pixel, otherwise drop valid on handshake.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_eof_q   <= 1'b0;
        end else if (pix_accept && word_end) begin
            m_valid_q <= 1'b1;
            m_data_q  <= word_d;
            m_keep_q  <= keep_d;
            m_last_q  <= frame_end || line_end;
            m_eof_q   <= frame_end;
        end else if (m_axis.tready) begin
            m_valid_q <= 1'b0;
        end
    end

    // Frame-done pulse follows the handshake of the frame's final word.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= out_hs && m_eof_q;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tkeep  = m_keep_q;
    assign m_axis.tlast  = m_last_q;
    assign o_frame_done  = frame_done_q;

endmodule
